// File: rtl/vip_cfg_router.sv
// Config write router: posted-write FIFO feeding one output stage that strobes one of three banks.
// Optional stall watchdog, enabled with VIP_CFG_TIMEOUT_EN, abandons a stuck write after TIMEOUT stalled edges.
module vip_cfg_router #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [8:0]  s_address,
    input  logic        s_write,
    input  logic [31:0] s_writedata,
    output logic        s_waitrequest,
    output logic [6:0]  m_address,
    output logic [31:0] m_writedata,
    output logic [2:0]  m_write,
    input  logic [2:0]  m_waitrequest,
    output logic        busy,
    output logic        err_unmapped,
    output logic        err_timeout,
    input  logic        err_clr
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [1:0]  bank;
        logic [6:0]  rgst;
        logic [31:0] data;
    } entry_t;

    entry_t          mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic            act_q, act_d;
    logic [1:0]      bank_q, bank_d;
    logic [6:0]      addr_q, addr_d;
    logic [31:0]     data_q, data_d;
    logic            err_unm_q, err_unm_d;

    entry_t          push_ent;
    entry_t          head;
    logic            push, pop, load, stall, done, abort, free, unm_set;

    // Full flag comes from the registered count only, so a same-edge pop never admits a push.
    assign s_waitrequest = (count_q == CW'(FIFO_DEPTH));
    assign push          = s_write & ~s_waitrequest;
    assign push_ent      = {s_address[8:7], s_address[6:0], s_writedata};
    assign head          = mem_q[rd_ptr_q];

    assign m_write     = act_q ? (3'b001 << bank_q) : 3'b000;
    assign m_address   = addr_q;
    assign m_writedata = data_q;
    assign stall       = |(m_write & m_waitrequest);
    assign done        = act_q & ~stall;
    assign free        = ~act_q | done | abort;
    assign pop         = (count_q != '0) & free;
    assign load        = pop & (head.bank != 2'd3);
    assign busy        = (count_q != '0) | act_q;
    assign err_unmapped = err_unm_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_ent;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // Output stage: a finishing write and the next load share one edge; bank 3 is popped and discarded.
    always_comb begin
        act_d   = act_q;
        bank_d  = bank_q;
        addr_d  = addr_q;
        data_d  = data_q;
        unm_set = 1'b0;
        if (free) begin
            act_d = 1'b0;
        end
        if (pop) begin
            if (head.bank == 2'd3) begin
                unm_set = 1'b1;
            end else begin
                act_d  = 1'b1;
                bank_d = head.bank;
                addr_d = head.rgst;
                data_d = head.data;
            end
        end
        err_unm_d = unm_set | (err_unm_q & ~err_clr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            act_q     <= 1'b0;
            bank_q    <= 2'd0;
            addr_q    <= 7'd0;
            data_q    <= 32'd0;
            err_unm_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            act_q     <= act_d;
            bank_q    <= bank_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            err_unm_q <= err_unm_d;
        end
    end

`ifdef VIP_CFG_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          err_to_q, err_to_d;

    // Counter saturates at TIMEOUT; the following stalled edge abandons the write.
    assign abort       = stall & (to_cnt_q == TW'(TIMEOUT));
    assign err_timeout = err_to_q;

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (load) begin
            to_cnt_d = '0;
        end else if (stall && (to_cnt_q != TW'(TIMEOUT))) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
        err_to_d = abort | (err_to_q & ~err_clr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_q <= '0;
            err_to_q <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_to_q <= err_to_d;
        end
    end
`else
    logic timeout_unused;

    assign timeout_unused = (TIMEOUT != 0);
    assign abort          = 1'b0;
    assign err_timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_vip_cfg_router.sv
// Directed bench for vip_cfg_router with a passive completion monitor.
module tb_vip_cfg_router;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [8:0]  s_address = '0;
    logic        s_write = 1'b0;
    logic [31:0] s_writedata = '0;
    logic        s_waitrequest;
    logic [6:0]  m_address;
    logic [31:0] m_writedata;
    logic [2:0]  m_write;
    logic [2:0]  m_waitrequest = 3'b000;
    logic        busy;
    logic        err_unmapped;
    logic        err_timeout;
    logic        err_clr = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    vip_cfg_router #(.FIFO_DEPTH(4), .TIMEOUT(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_address    (s_address),
        .s_write      (s_write),
        .s_writedata  (s_writedata),
        .s_waitrequest(s_waitrequest),
        .m_address    (m_address),
        .m_writedata  (m_writedata),
        .m_write      (m_write),
        .m_waitrequest(m_waitrequest),
        .busy         (busy),
        .err_unmapped (err_unmapped),
        .err_timeout  (err_timeout),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    // Monitor: completions with their cycle, strobe activity, one-hot and stability violations.
    logic [41:0] comp_q[$];
    int          cyc_q[$];
    int          cycle = 0;
    int          strobe_cnt = 0;
    int          onehot_bad = 0;
    int          stable_bad = 0;
    logic        hold_prev = 1'b0;
    logic [38:0] prev_ad;

    always @(posedge clk) begin
        cycle++;
        if (!reset) begin
            if ($countones(m_write) > 1) onehot_bad++;
            if (m_write != 3'b000) strobe_cnt++;
            if (hold_prev && m_write != 3'b000 && {m_address, m_writedata} != prev_ad) stable_bad++;
            if (m_write != 3'b000 && (m_write & m_waitrequest) == 3'b000) begin
                comp_q.push_back({m_write, m_address, m_writedata});
                cyc_q.push_back(cycle);
            end
            hold_prev = (m_write & m_waitrequest) != 3'b000;
            prev_ad   = {m_address, m_writedata};
        end else begin
            hold_prev = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [8:0] a, input logic [31:0] d);
        int k;
        s_address   = a;
        s_writedata = d;
        s_write     = 1'b1;
        for (k = 0; k < 50; k++) begin
            if (!s_waitrequest) begin
                tick();
                break;
            end
            tick();
        end
        s_write = 1'b0;
        check("push_accept", 64'(k < 50), 64'd1);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        for (k = 0; k < 100 && (busy || m_write != 3'b000); k++) tick();
        check(tag, 64'(busy), 64'd0);
    endtask

    initial begin
        int base;
        // Reset state
        #1;
        check("rst_waitreq", 64'(s_waitrequest), 64'd0);
        check("rst_mwrite", 64'(m_write), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_addr", 64'(m_address), 64'd0);
        check("rst_data", 64'(m_writedata), 64'd0);
        check("rst_errs", 64'({err_unmapped, err_timeout}), 64'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_waitreq", 64'(s_waitrequest), 64'd0);

        // Single write, one-edge latency
        push(9'h10A, 32'h1E0);
        check("single_e0_mwrite", 64'(m_write), 64'd0);
        check("single_e0_busy", 64'(busy), 64'd1);
        tick();
        check("single_mwrite", 64'(m_write), 64'b100);
        check("single_addr", 64'(m_address), 64'h0A);
        check("single_data", 64'(m_writedata), 64'h1E0);
        tick();
        check("single_done_mwrite", 64'(m_write), 64'd0);
        check("single_done_busy", 64'(busy), 64'd0);

        // Backpressure on bank 1
        comp_q.delete();
        cyc_q.delete();
        m_waitrequest = 3'b010;
        for (int i = 1; i <= 5; i++) push(9'h080 | 9'(i), 32'hA000_0000 + i);
        check("bp_full", 64'(s_waitrequest), 64'd1);
        check("bp_mwrite", 64'(m_write), 64'b010);
        check("bp_addr", 64'(m_address), 64'h01);
        s_address   = 9'h086;
        s_writedata = 32'hA000_0006;
        s_write     = 1'b1;
        tick();
        tick();
        tick();
        check("bp_still_full", 64'(s_waitrequest), 64'd1);
        check("bp_addr_stable", 64'(m_writedata), 64'hA000_0001);
        m_waitrequest = 3'b000;
        push(9'h086, 32'hA000_0006);
        wait_idle("bp_idle");
        check("bp_count", 64'(comp_q.size()), 64'd6);
        if (comp_q.size() == 6) begin
            for (int i = 0; i < 6; i++)
                check("bp_order", 64'(comp_q[i]), 64'({3'b010, 7'(i + 1), 32'hA000_0000 + 32'(i + 1)}));
            for (int i = 1; i < 5; i++)
                check("bp_b2b", 64'(cyc_q[i] - cyc_q[i-1]), 64'd1);
        end

        // Mixed banks 2,1,0,2
        comp_q.delete();
        push(9'h111, 32'hDEAD_0001);
        push(9'h0A2, 32'hDEAD_0002);
        push(9'h033, 32'hDEAD_0003);
        push(9'h144, 32'hFFFF_FFFF);
        wait_idle("mix_idle");
        check("mix_count", 64'(comp_q.size()), 64'd4);
        if (comp_q.size() == 4) begin
            check("mix_0", 64'(comp_q[0]), 64'({3'b100, 7'h11, 32'hDEAD_0001}));
            check("mix_1", 64'(comp_q[1]), 64'({3'b010, 7'h22, 32'hDEAD_0002}));
            check("mix_2", 64'(comp_q[2]), 64'({3'b001, 7'h33, 32'hDEAD_0003}));
            check("mix_3", 64'(comp_q[3]), 64'({3'b100, 7'h44, 32'hFFFF_FFFF}));
        end
        check("mix_onehot", 64'(onehot_bad), 64'd0);

        // Unmapped bank 3
        base = strobe_cnt;
        push(9'h180, 32'h55);
        check("unm_pre_err", 64'(err_unmapped), 64'd0);
        check("unm_pre_busy", 64'(busy), 64'd1);
        tick();
        check("unm_err", 64'(err_unmapped), 64'd1);
        check("unm_busy", 64'(busy), 64'd0);
        tick();
        check("unm_no_strobe", 64'(strobe_cnt - base), 64'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("unm_clr", 64'(err_unmapped), 64'd0);
        push(9'h181, 32'h66);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("unm_set_wins", 64'(err_unmapped), 64'd1);

        // Reset with 3 queued and 1 stalled
        m_waitrequest = 3'b001;
        for (int i = 1; i <= 4; i++) push(9'(i), 32'hB000_0000 + i);
        check("rstop_busy_pre", 64'(busy), 64'd1);
        check("rstop_mwrite_pre", 64'(m_write), 64'b001);
        reset = 1'b1;
        #1;
        check("rstop_mwrite", 64'(m_write), 64'd0);
        check("rstop_busy", 64'(busy), 64'd0);
        check("rstop_waitreq", 64'(s_waitrequest), 64'd0);
        check("rstop_err", 64'(err_unmapped), 64'd0);
        tick();
        tick();
        reset = 1'b0;
        m_waitrequest = 3'b000;
        base = strobe_cnt;
        for (int i = 0; i < 6; i++) tick();
        check("rstop_no_strobe", 64'(strobe_cnt - base), 64'd0);
        check("rstop_idle", 64'(busy), 64'd0);

`ifdef VIP_CFG_TIMEOUT_EN
        // Watchdog: bank 0 stuck, bank 2 write behind it
        comp_q.delete();
        m_waitrequest = 3'b001;
        push(9'h005, 32'h77);
        push(9'h106, 32'h88);
        for (int i = 0; i < 8; i++) tick();
        check("to_still_stalled", 64'(m_write), 64'b001);
        check("to_err_pre", 64'(err_timeout), 64'd0);
        tick();
        check("to_next_issued", 64'(m_write), 64'b100);
        check("to_next_addr", 64'(m_address), 64'h06);
        check("to_err", 64'(err_timeout), 64'd1);
        wait_idle("to_idle");
        check("to_count", 64'(comp_q.size()), 64'd1);
        if (comp_q.size() == 1)
            check("to_comp", 64'(comp_q[0]), 64'({3'b100, 7'h06, 32'h88}));
        m_waitrequest = 3'b000;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("to_clr", 64'(err_timeout), 64'd0);
`else
        // Without the watchdog a stall is waited out indefinitely
        comp_q.delete();
        m_waitrequest = 3'b001;
        push(9'h005, 32'h77);
        for (int i = 0; i < 20; i++) tick();
        check("nto_stalled", 64'(m_write), 64'b001);
        check("nto_err", 64'(err_timeout), 64'd0);
        m_waitrequest = 3'b000;
        wait_idle("nto_idle");
        check("nto_count", 64'(comp_q.size()), 64'd1);
        if (comp_q.size() == 1)
            check("nto_comp", 64'(comp_q[0]), 64'({3'b001, 7'h05, 32'h77}));
`endif

        check("final_onehot", 64'(onehot_bad), 64'd0);
        check("final_stable", 64'(stable_bad), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
